// File: rtl/pc_fetch_controller.sv
// Program-counter fetch sequencer: issues word fetches over a req/ack handshake and
// delivers instruction/PC pairs to decode over valid/ready, with stall, redirect and fault handling.
module pc_fetch_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned MAX_WAIT     = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic        fetch_error
);

    typedef enum logic [2:0] {BOOT, REQ, DELIVER, HOLD, HALT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state, state_n;
    logic [31:0] pc_n, instr_n, instr_pc_n;
    logic [31:0] target_q, target_n;
    logic        req_n, valid_n, error_n;
    logic        squash_q, squash_n;
    logic        halt_pend_q, halt_pend_n;
    logic [7:0]  wait_q, wait_n;
    logic        redir_ok, redir_bad;

    assign redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign imem_addr = pc;

    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
        state_n     = state;
        pc_n        = pc;
        req_n       = imem_req;
        valid_n     = instr_valid;
        instr_n     = instr;
        instr_pc_n  = instr_pc;
        error_n     = fetch_error;
        target_n    = target_q;
        squash_n    = squash_q;
        halt_pend_n = halt_pend_q;
        wait_n      = wait_q;

        // A misaligned redirect faults at once but halts only once nothing is outstanding.
        if (redir_bad && state != HALT) begin
            error_n     = 1'b1;
            halt_pend_n = 1'b1;
        end

        case (state)
            BOOT: begin
                if (halt_pend_n) begin
                    state_n = HALT;
                end else begin
                    if (redir_ok) pc_n = redirect_target;
                    state_n = REQ;
                    req_n   = 1'b1;
                end
            end

            REQ: begin
                if (!imem_req) begin
                    // Idle gap after a discarded response; the next request goes out now.
                    if (halt_pend_n) begin
                        state_n = HALT;
                    end else begin
                        if (redir_ok) pc_n = redirect_target;
                        req_n = 1'b1;
                    end
                end else if (imem_ack) begin
                    wait_n = 8'd0;
                    req_n  = 1'b0;
                    if (halt_pend_n) begin
                        squash_n = 1'b0;
                        state_n  = HALT;
                    end else if (redir_ok) begin
                        squash_n = 1'b0;
                        pc_n     = redirect_target;
                    end else if (squash_q) begin
                        squash_n = 1'b0;
                        pc_n     = target_q;
                    end else begin
                        instr_n    = imem_rdata;
                        instr_pc_n = pc;
                        pc_n       = pc + 32'd4;
                        valid_n    = 1'b1;
                        state_n    = DELIVER;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    req_n   = 1'b0;
                    error_n = 1'b1;
                    state_n = HALT;
                end else begin
                    wait_n = wait_q + 8'd1;
                    if (redir_ok) begin
                        squash_n = 1'b1;
                        target_n = redirect_target;
                    end
                end
            end

            DELIVER: begin
                if (halt_pend_n) begin
                    valid_n = 1'b0;
                    state_n = HALT;
                end else if (redir_ok || instr_ready) begin
                    valid_n = 1'b0;
                    if (redir_ok) pc_n = redirect_target;
                    if (stall) begin
                        state_n = HOLD;
                    end else begin
                        state_n = REQ;
                        req_n   = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (halt_pend_n) begin
                    state_n = HALT;
                end else begin
                    if (redir_ok) pc_n = redirect_target;
                    if (!stall) begin
                        state_n = REQ;
                        req_n   = 1'b1;
                    end
                end
            end

            default: begin
                req_n   = 1'b0;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= 32'd0;
            instr_pc    <= 32'd0;
            fetch_error <= 1'b0;
            target_q    <= 32'd0;
            squash_q    <= 1'b0;
            halt_pend_q <= 1'b0;
            wait_q      <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state       <= state_n;
            pc          <= pc_n;
            imem_req    <= req_n;
            instr_valid <= valid_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
            fetch_error <= error_n;
            target_q    <= target_n;
            squash_q    <= squash_n;
            halt_pend_q <= halt_pend_n;
            wait_q      <= wait_n;
        end
    end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Self-checking bench for pc_fetch_controller: directed scenarios plus a randomized run
// scored against a transaction-level model of the delivered instruction stream.
module tb_pc_fetch_controller;

    localparam logic [31:0] RV_B = 32'hFFFF_FFF8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_ready = 1'b0;

    logic        imem_req, instr_valid, fetch_error;
    logic [31:0] imem_addr, instr, instr_pc, pc;
    logic        imem_req_b, instr_valid_b, fetch_error_b;
    logic [31:0] imem_addr_b, instr_b, instr_pc_b, pc_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    pc_fetch_controller dut (
        .clock(clock), .reset_n(reset_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .pc(pc), .fetch_error(fetch_error)
    );

    pc_fetch_controller #(.RESET_VECTOR(RV_B), .MAX_WAIT(16)) dut_b (
        .clock(clock), .reset_n(reset_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid_b), .instr(instr_b), .instr_pc(instr_pc_b), .instr_ready(instr_ready),
        .pc(pc_b), .fetch_error(fetch_error_b)
    );

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
        imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc got %h exp %h", pc, 32'h0); else n_pass++;
        n_checks++; if (pc_b !== RV_B) $display("FAIL reset_pc_b got %h exp %h", pc_b, RV_B); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", imem_req); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", instr_valid); else n_pass++;
        n_checks++; if (instr !== 32'h0) $display("FAIL reset_instr got %h exp 0", instr); else n_pass++;
        n_checks++; if (instr_pc !== 32'h0) $display("FAIL reset_instr_pc got %h exp 0", instr_pc); else n_pass++;
        n_checks++; if (fetch_error !== 1'b0) $display("FAIL reset_err got %b exp 0", fetch_error); else n_pass++;
    endtask

    // Ack and ready tied high: request in odd cycles, delivery in even cycles.
    task automatic test_sequential();
        logic [31:0] exp_addr;
        apply_reset();
        imem_ack = 1'b1; instr_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            imem_rdata = mem_word(imem_addr);
            n_checks++; if (imem_req !== k[0]) $display("FAIL seq_req k=%0d got %b exp %b", k, imem_req, k[0]); else n_pass++;
            if (k[0]) begin
                exp_addr = 32'(2 * (k - 1));
                n_checks++; if (imem_addr !== exp_addr) $display("FAIL seq_addr k=%0d got %h exp %h", k, imem_addr, exp_addr); else n_pass++;
            end else begin
                exp_addr = 32'(2 * (k - 2));
                n_checks++; if (instr_valid !== 1'b1) $display("FAIL seq_valid k=%0d got %b exp 1", k, instr_valid); else n_pass++;
                n_checks++; if (instr_pc !== exp_addr) $display("FAIL seq_instr_pc k=%0d got %h exp %h", k, instr_pc, exp_addr); else n_pass++;
                n_checks++; if (instr !== mem_word(exp_addr)) $display("FAIL seq_instr k=%0d got %h exp %h", k, instr, mem_word(exp_addr)); else n_pass++;
            end
        end
    endtask

    task automatic test_delayed();
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            imem_ack = 1'b0; instr_ready = 1'b0;
            if (k <= 4) begin
                n_checks++; if (imem_req !== 1'b1) $display("FAIL dly_req k=%0d got %b exp 1", k, imem_req); else n_pass++;
                n_checks++; if (imem_addr !== 32'h0) $display("FAIL dly_addr k=%0d got %h exp 0", k, imem_addr); else n_pass++;
                imem_ack = (k == 4);
                imem_rdata = mem_word(32'h0);
            end else if (k <= 7) begin
                n_checks++; if (instr_valid !== 1'b1) $display("FAIL dly_valid k=%0d got %b exp 1", k, instr_valid); else n_pass++;
                n_checks++; if (instr_pc !== 32'h0) $display("FAIL dly_instr_pc k=%0d got %h exp 0", k, instr_pc); else n_pass++;
                n_checks++; if (instr !== mem_word(32'h0)) $display("FAIL dly_instr k=%0d got %h exp %h", k, instr, mem_word(32'h0)); else n_pass++;
                instr_ready = (k == 7);
            end else begin
                n_checks++; if (instr_valid !== 1'b0) $display("FAIL dly_valid_drop got %b exp 0", instr_valid); else n_pass++;
                n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL dly_next got req=%b addr=%h exp req=1 addr=4", imem_req, imem_addr); else n_pass++;
            end
        end
    endtask

    task automatic test_squash();
        logic seen;
        apply_reset();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL sq_pending k=%0d got req=%b addr=%h exp req=1 addr=0", k, imem_req, imem_addr); else n_pass++;
            redirect_valid = (k == 1);
            redirect_target = 32'h0000_0100;
            imem_ack = (k == 3);
            imem_rdata = mem_word(imem_addr);
        end
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clock);
            imem_ack = 1'b0;
            n_checks++; if (instr_valid !== 1'b0) $display("FAIL sq_leak got valid=%b exp 0", instr_valid); else n_pass++;
            if (imem_req) begin
                seen = 1'b1;
                n_checks++; if (imem_addr !== 32'h100) $display("FAIL sq_target got %h exp %h", imem_addr, 32'h100); else n_pass++;
                imem_ack = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end
        end
        n_checks++; if (!seen) $display("FAIL sq_refetch got none exp request within 4 cycles"); else n_pass++;
        @(negedge clock);
        imem_ack = 1'b0; instr_ready = 1'b1;
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) $display("FAIL sq_deliver got valid=%b pc=%h exp valid=1 pc=100", instr_valid, instr_pc); else n_pass++;
        n_checks++; if (instr !== mem_word(32'h100)) $display("FAIL sq_instr got %h exp %h", instr, mem_word(32'h100)); else n_pass++;
        n_checks++; if (fetch_error !== 1'b0) $display("FAIL sq_err got %b exp 0", fetch_error); else n_pass++;
    endtask

    task automatic test_stall();
        apply_reset();
        imem_ack = 1'b1; instr_ready = 1'b1;
        @(negedge clock);
        imem_rdata = mem_word(imem_addr);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL st_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); else n_pass++;
        @(negedge clock);
        n_checks++; if (instr_valid !== 1'b1 || instr !== mem_word(32'h0)) $display("FAIL st_deliver got valid=%b instr=%h exp valid=1 instr=%h", instr_valid, instr, mem_word(32'h0)); else n_pass++;
        stall = 1'b1; imem_ack = 1'b0;
        for (int k = 3; k <= 7; k++) begin
            @(negedge clock);
            n_checks++; if (imem_req !== 1'b0) $display("FAIL st_hold k=%0d got req=%b exp 0", k, imem_req); else n_pass++;
            if (k == 7) stall = 1'b0;
        end
        @(negedge clock);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL st_resume got req=%b addr=%h exp req=1 addr=4", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr;
        apply_reset();
        imem_ack = 1'b1; instr_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            imem_rdata = mem_word(imem_addr_b);
            if (k[0]) begin
                exp_addr = RV_B + 32'(2 * (k - 1));
                n_checks++; if (imem_req_b !== 1'b1 || imem_addr_b !== exp_addr) $display("FAIL wrap_addr k=%0d got req=%b addr=%h exp req=1 addr=%h", k, imem_req_b, imem_addr_b, exp_addr); else n_pass++;
            end else begin
                exp_addr = RV_B + 32'(2 * (k - 2));
                n_checks++; if (instr_valid_b !== 1'b1 || instr_pc_b !== exp_addr) $display("FAIL wrap_deliver k=%0d got valid=%b pc=%h exp valid=1 pc=%h", k, instr_valid_b, instr_pc_b, exp_addr); else n_pass++;
            end
        end
        n_checks++; if (fetch_error_b !== 1'b0) $display("FAIL wrap_err got %b exp 0", fetch_error_b); else n_pass++;
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            n_checks++; if (imem_req !== 1'b1 || fetch_error !== 1'b0) $display("FAIL to_wait k=%0d got req=%b err=%b exp req=1 err=0", k, imem_req, fetch_error); else n_pass++;
        end
        @(negedge clock);
        n_checks++; if (imem_req !== 1'b0 || fetch_error !== 1'b1) $display("FAIL to_fire got req=%b err=%b exp req=0 err=1", imem_req, fetch_error); else n_pass++;
        imem_ack = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            redirect_valid = 1'b0;
            n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_error !== 1'b1 || pc !== 32'h0)
                $display("FAIL to_halt got req=%b valid=%b err=%b pc=%h exp 0 0 1 0", imem_req, instr_valid, fetch_error, pc); else n_pass++;
        end
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (fetch_error !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0) $display("FAIL to_reset got err=%b req=%b pc=%h exp 0 0 0", fetch_error, imem_req, pc); else n_pass++;
    endtask

    task automatic test_misaligned();
        apply_reset();
        imem_ack = 1'b1; instr_ready = 1'b1;
        @(negedge clock);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL mis_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); else n_pass++;
        imem_rdata = mem_word(imem_addr);
        redirect_valid = 1'b1; redirect_target = 32'h0000_0102;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clock);
            redirect_valid = 1'b0;
            n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || fetch_error !== 1'b1 || pc !== 32'h0)
                $display("FAIL mis_halt k=%0d got valid=%b req=%b err=%b pc=%h exp 0 0 1 0", k, instr_valid, imem_req, fetch_error, pc); else n_pass++;
        end
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (fetch_error !== 1'b0) $display("FAIL mis_reset got err=%b exp 0", fetch_error); else n_pass++;
    endtask

    // Model: decode must see consecutive words, restarting at the target after each redirect.
    task automatic test_random();
        logic [31:0] exp_pc, prev_addr, prev_instr, prev_ipc;
        logic        prev_req, prev_ack, prev_valid, prev_consumed, hs;
        int          lat, waited, n_hs;
        apply_reset();
        exp_pc = 32'h0; prev_addr = 32'h0; prev_instr = 32'h0; prev_ipc = 32'h0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0; prev_consumed = 1'b0;
        lat = $urandom_range(0, 4); waited = 0; n_hs = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clock);
            if (imem_req && prev_req && !prev_ack) begin
                n_checks++; if (imem_addr !== prev_addr) $display("FAIL rnd_addr_stable cyc=%0d got %h exp %h", k, imem_addr, prev_addr); else n_pass++;
            end
            if (instr_valid && prev_valid && !prev_consumed) begin
                n_checks++; if (instr !== prev_instr || instr_pc !== prev_ipc)
                    $display("FAIL rnd_hold cyc=%0d got %h@%h exp %h@%h", k, instr, instr_pc, prev_instr, prev_ipc); else n_pass++;
            end
            stall = ($urandom_range(0, 3) == 0);
            instr_ready = 1'($urandom_range(0, 1));
            hs = instr_valid && instr_ready;
            redirect_valid = 1'b0;
            if (!hs && $urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                redirect_target = $urandom() & 32'hFFFF_FFFC;
            end
            imem_ack = 1'b0;
            if (imem_req) begin
                if (waited == lat) begin
                    imem_ack = 1'b1; waited = 0; lat = $urandom_range(0, 4);
                end else begin
                    waited++;
                end
            end
            imem_rdata = mem_word(imem_addr);
            if (hs) begin
                n_checks++; if (instr_pc !== exp_pc || instr !== mem_word(exp_pc))
                    $display("FAIL rnd_deliver cyc=%0d got %h@%h exp %h@%h", k, instr, instr_pc, mem_word(exp_pc), exp_pc); else n_pass++;
                exp_pc = exp_pc + 32'd4;
                n_hs++;
            end
            if (redirect_valid) exp_pc = redirect_target;
            prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
            prev_valid = instr_valid; prev_instr = instr; prev_ipc = instr_pc;
            prev_consumed = hs || redirect_valid;
        end
        n_checks++; if (fetch_error !== 1'b0) $display("FAIL rnd_err got %b exp 0", fetch_error); else n_pass++;
        n_checks++; if (n_hs < 40) $display("FAIL rnd_progress got %0d deliveries exp >= 40", n_hs); else n_pass++;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_delayed();
        test_squash();
        test_stall();
        test_wrap();
        test_timeout();
        test_misaligned();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_controller.md
Name: pc_fetch_controller

Overview:
Sequences the 32-bit program counter through instruction fetch. It issues word-aligned fetch requests to instruction memory using a req/ack handshake, and hands each fetched instruction and its PC to the decode stage using a valid/ready handshake. It also applies stall and branch/jump redirects, and detects fetch faults. It sits between the program counter, instruction memory and decode, and replaces the free-running +4 counter.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded at reset; must be word-aligned.
MAX_WAIT, 16, maximum cycles imem_req may stay high without imem_ack before a timeout fault; legal range 1..255.

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset_n  input  1  asynchronous, active-low reset
stall  input  1  when high, no new fetch is started
redirect_valid  input  1  one-cycle pulse: load redirect_target into the PC
redirect_target  input  32  branch/jump target address
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; equals pc
imem_ack  input  1  memory has returned data this cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
instr_valid  output  1  instr and instr_pc are valid for decode
instr  output  32  fetched instruction
instr_pc  output  32  address that instr was fetched from
instr_ready  input  1  decode accepts the instruction
pc  output  32  current fetch PC
fetch_error  output  1  sticky fault flag

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_VECTOR; imem_req=0; instr_valid=0; instr=0; instr_pc=0; fetch_error=0; wait counter=0.
  - state=BOOT.
- States: BOOT, REQ, DELIVER, HOLD, HALT. Outputs are registered, except imem_addr, which is wired to pc.
- BOOT: goes to REQ on the next cycle, whatever the value of stall.
- REQ:
  - imem_req=1. The request is never withdrawn before imem_ack, except on timeout. pc and imem_addr stay stable while imem_req=1.
  - On imem_ack (ack may arrive in the first REQ cycle): instr<=imem_rdata; instr_pc<=pc; pc<=pc+4; instr_valid<=1; go to DELIVER.
  - The wait counter increments each REQ cycle without ack and clears on ack.
  - If the counter reaches MAX_WAIT with no ack: imem_req<=0, fetch_error<=1, go to HALT.
- DELIVER:
  - instr_valid=1; instr and instr_pc are held stable until instr_ready.
  - On instr_valid&&instr_ready: instr_valid<=0, then go to REQ if stall=0, otherwise to HOLD.
- HOLD: leave for REQ in the first cycle where stall=0.
- HALT: imem_req=0, instr_valid=0. Only reset exits HALT.
- stall is sampled only on the DELIVER handshake and in HOLD. It never aborts an outstanding request.
- Redirect (priority over +4; ignored in HALT):
  - Misaligned target (redirect_target[1:0]!=0): pc is unchanged; fetch_error<=1; go to HALT after any outstanding request completes. The acked data is discarded.
  - REQ, no ack this cycle: pc and imem_addr stay stable; a squash flag is set. When the ack arrives, the data is discarded, instr_valid stays 0, pc<=redirect_target, and the state stays in REQ to issue the target fetch on the next cycle.
  - REQ, ack in the same cycle: the data is discarded; pc<=redirect_target; stay in REQ (imem_req drops for one cycle, then re-asserts).
  - DELIVER: instr_valid<=0 even without ready (instruction squashed); pc<=redirect_target; go to REQ, or to HOLD if stall=1.
  - BOOT/HOLD: pc<=redirect_target; the next transition is unchanged.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no fault.
- Throughput: at best one instruction every 2 cycles (ack in REQ, ready in DELIVER).
- Reset mid-operation: all outputs return to their reset values immediately; the squash flag and wait counter are cleared.

Test Plan:
- Reset release, imem_ack tied high, instr_ready tied high → imem_addr sequence 0,4,8,C, one instruction every 2 cycles; instr_pc matches each address.
- Ack delayed 3 cycles, instr_ready low for 2 cycles → imem_req held 4 cycles with addr stable; instr/instr_pc stable while instr_valid=1 and ready=0.
- Redirect to 32'h0000_0100 during an outstanding request, ack 2 cycles later → that data never reaches instr_valid; next imem_addr=0x100; fetch_error=0.
- stall=1 at the DELIVER handshake for 5 cycles → imem_req=0 for those 5 cycles, then a fetch at the next sequential address.
- RESET_VECTOR=32'hFFFF_FFF8 → fetches at FFFF_FFF8, FFFF_FFFC, then 0000_0000; no fault.
- imem_ack never asserted → imem_req drops and fetch_error=1 after MAX_WAIT=16 cycles, HALT holds. Separately, redirect target 0x102 → fetch_error=1, HALT; reset_n low clears both.
